// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// address bits that pick a byte lane inside a memory word.
package lsu_pkg;

  localparam int WORD_W = 32;

  // Address bits that select a byte lane in a little-endian 32-bit word.
  localparam int LANE_LSB = 0;
  localparam int LANE_MSB = 1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: merges store lanes into the word read back from memory
// and extracts/extends the addressed lanes for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              uns,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] merged,
  output logic [WORD_W-1:0] load_res
);

  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] wrep;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;

  always_comb begin
    mask = '1;
    wrep = wdata;
    // Replicate the store data into every lane; the mask keeps only the target.
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        wrep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        wrep = {2{wdata[15:0]}};
      end
      default: begin
        mask = '1;
        wrep = wdata;
      end
    endcase
    merged = (rdata & ~mask) | (wrep & mask);
  end

  always_comb begin
    byte_val = rdata[{lane, 3'b000} +: 8];
    half_val = rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_res = {{24{~uns & byte_val[7]}}, byte_val};
      SZ_HALF: load_res = {{16{~uns & half_val[15]}}, half_val};
      default: load_res = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request in, one response out, with read-modify-write
// for sub-word stores and misalignment faults that never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              _clk,
  input  logic              _reset,
  input  logic              _req_valid,
  output logic              req_ready_,
  input  logic              _req_we,
  input  logic [1:0]        _req_size,
  input  logic              _req_unsigned,
  input  logic [ADDR_W-1:0] _req_vptr,
  input  logic [DATA_W-1:0] _req_data,
  output logic              resp_valid_,
  input  logic              _resp_ready,
  output logic [DATA_W-1:0] resp_data_,
  output logic              resp_misaligned_,
  output logic              mem_we_,
  output logic [ADDR_W-1:0] mem_vptr_,
  output logic [DATA_W-1:0] mem_data_,
  input  logic [DATA_W-1:0] _mem_value,
  output logic [1:0]        state_dbg_
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both
  // high; valid never waits on ready, and response fields hold until taken.

  lsu_state_e state, state_n;

  logic              we_q;
  logic              uns_q;
  logic              mis_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_res;
  logic [ADDR_W-1:0] aligned_ptr;
  logic              accept;

  // Ready is gated by reset so it reads 0 while reset is held.
  assign req_ready_  = _reset && (state == IDLE);
  assign accept      = _req_valid && req_ready_;
  assign aligned_ptr = {addr_q[ADDR_W-1:2], 2'b00};
  assign state_dbg_  = state;

  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_misaligned(_req_size, _req_vptr[LANE_MSB:LANE_LSB])) state_n = RESP;
          else if (_req_we && (_req_size == SZ_WORD))                 state_n = WR;
          else                                                        state_n = RD;
        end
      end
      RD:      state_n = we_q ? WR : RESP;
      WR:      state_n = RESP;
      RESP:    if (_resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= _req_we;
        uns_q   <= _req_unsigned;
        mis_q   <= is_misaligned(_req_size, _req_vptr[LANE_MSB:LANE_LSB]);
        size_q  <= _req_size;
        addr_q  <= _req_vptr;
        wdata_q <= _req_data;
      end
      if (state == RD) rdata_q <= _mem_value;
    end
  end

  lsu_lane_align u_align (
    .size     (size_q),
    .lane     (addr_q[LANE_MSB:LANE_LSB]),
    .uns      (uns_q),
    .rdata    (rdata_q),
    .wdata    (wdata_q),
    .merged   (merged),
    .load_res (load_res)
  );

  assign mem_we_          = (state == WR);
  assign mem_vptr_        = ((state == RD) || (state == WR)) ? aligned_ptr : '0;
  assign mem_data_        = (state == WR) ? merged : '0;
  assign resp_valid_      = (state == RESP);
  assign resp_misaligned_ = (state == RESP) && mis_q;
  // Stores and faults answer with zero; loads present the extended lanes.
  assign resp_data_       = ((state == RESP) && !we_q && !mis_q) ? load_res : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 64-word memory, a byte-level reference model and
// a per-cycle compare process, plus directed scenarios pinned by literals.
module tb_load_store_unit;

  logic        _clk;
  logic        _reset;
  logic        _req_valid;
  logic        req_ready_;
  logic        _req_we;
  logic [1:0]  _req_size;
  logic        _req_unsigned;
  logic [31:0] _req_vptr;
  logic [31:0] _req_data;
  logic        resp_valid_;
  logic        _resp_ready;
  logic [31:0] resp_data_;
  logic        resp_misaligned_;
  logic        mem_we_;
  logic [31:0] mem_vptr_;
  logic [31:0] mem_data_;
  logic [31:0] _mem_value;
  logic [1:0]  state_dbg_;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    ._clk             (_clk),
    ._reset           (_reset),
    ._req_valid       (_req_valid),
    .req_ready_       (req_ready_),
    ._req_we          (_req_we),
    ._req_size        (_req_size),
    ._req_unsigned    (_req_unsigned),
    ._req_vptr        (_req_vptr),
    ._req_data        (_req_data),
    .resp_valid_      (resp_valid_),
    ._resp_ready      (_resp_ready),
    .resp_data_       (resp_data_),
    .resp_misaligned_ (resp_misaligned_),
    .mem_we_          (mem_we_),
    .mem_vptr_        (mem_vptr_),
    .mem_data_        (mem_data_),
    ._mem_value       (_mem_value),
    .state_dbg_       (state_dbg_)
  );

  // ---------------- clock ----------------
  initial _clk = 1'b0;
  always #5 _clk = ~_clk;

  // ---------------- memory ----------------
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  assign _mem_value = mem[mem_vptr_[7:2]];
  always @(posedge _clk) if (mem_we_) mem[mem_vptr_[7:2]] = mem_data_;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input int unsigned a, input logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    case (sz)
      2'd0: b[a % 4] = d[7:0];
      2'd1: begin
        b[a % 4]     = d[7:0];
        b[a % 4 + 1] = d[15:8];
      end
      default: for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input int unsigned a, input logic uns);
    int unsigned v;
    case (sz)
      2'd0: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic        run_chk = 1'b0;
  logic        m_active;
  int          m_cnt, m_lat, m_idx;
  logic        m_wr, m_rd, m_mis, m_ew, m_ev;
  logic [31:0] m_ptr, m_wdata, m_exp;
  logic [31:0] exp_q[$];
  logic        exp_mis_q[$];

  always @(negedge _clk or negedge _reset) begin
    if (!_reset) begin
      m_active = 1'b0;
      m_cnt    = 0;
      exp_q.delete();
      exp_mis_q.delete();
    end else if (run_chk) begin
      if (m_active) m_cnt++;
      m_ew = m_active && m_wr && (m_cnt == m_lat - 1);
      m_ev = m_active && (m_cnt >= m_lat);
      check("mem_we", mem_we_, m_ew);
      if (m_ew) begin
        check("wr_ptr", mem_vptr_, m_ptr);
        check("wr_data", mem_data_, m_wdata);
      end else if (m_active && m_rd && m_cnt == 1) begin
        check("rd_ptr", mem_vptr_, m_ptr);
        check("rd_data_idle", mem_data_, 32'h0);
      end else begin
        check("ptr_idle", mem_vptr_, 32'h0);
        check("data_idle", mem_data_, 32'h0);
      end
      check("resp_valid", resp_valid_, m_ev);
      check("req_ready", req_ready_, !m_active);
      if (m_ev && exp_q.size() > 0) begin
        check("resp_data", resp_data_, exp_q[0]);
        check("resp_mis", resp_misaligned_, exp_mis_q[0]);
      end
      if (m_ev && _resp_ready) begin
        void'(exp_q.pop_front());
        void'(exp_mis_q.pop_front());
        if (m_wr) ref_mem[m_idx] = m_wdata;
        m_active = 1'b0;
      end else if (!m_active && _req_valid && req_ready_) begin
        m_mis = (_req_size == 2'd3) || (_req_size == 2'd1 && _req_vptr % 2 != 0) ||
                (_req_size == 2'd2 && _req_vptr % 4 != 0);
        m_ptr = _req_vptr - (_req_vptr % 4);
        m_idx = int'(_req_vptr[7:2]);
        if (m_mis) begin
          m_lat = 1; m_wr = 1'b0; m_rd = 1'b0; m_exp = 32'h0;
        end else if (_req_we) begin
          m_lat   = (_req_size == 2'd2) ? 2 : 3;
          m_wr    = 1'b1;
          m_rd    = (_req_size != 2'd2);
          m_wdata = model_store(ref_mem[m_idx], _req_size, _req_vptr, _req_data);
          m_exp   = 32'h0;
        end else begin
          m_lat = 2; m_wr = 1'b0; m_rd = 1'b1;
          m_exp = model_load(ref_mem[m_idx], _req_size, _req_vptr, _req_unsigned);
        end
        exp_q.push_back(m_exp);
        exp_mis_q.push_back(m_mis);
        m_active = 1'b1;
        m_cnt    = 0;
      end
    end
  end

  // Write-pulse and read-pointer log for the directed literal checks.
  int          we_pulses = 0;
  logic [31:0] last_we_ptr, last_we_data, last_rd_ptr;
  always @(negedge _clk) begin
    if (_reset && mem_we_) begin
      we_pulses++;
      last_we_ptr  = mem_vptr_;
      last_we_data = mem_data_;
    end
    if (_reset && !mem_we_ && mem_vptr_ != 32'h0) last_rd_ptr = mem_vptr_;
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] vptr, input logic [31:0] data,
                        input int stall, input logic spam,
                        output logic [31:0] rd, output logic mis,
                        output int lat, output int acc_wait);
    rd = '0; mis = 1'b0; lat = 0; acc_wait = 0;
    @(posedge _clk); #1;
    _req_valid = 1'b1; _req_we = we; _req_size = sz; _req_unsigned = uns;
    _req_vptr = vptr; _req_data = data; _resp_ready = (stall == 0);
    @(negedge _clk);
    while (!req_ready_ && acc_wait < 20) begin
      @(negedge _clk);
      acc_wait++;
    end
    if (!req_ready_) begin
      check("accept_timeout", req_ready_, 1'b1);
      _req_valid = 1'b0;
      return;
    end
    @(posedge _clk); #1;
    if (spam) begin
      _req_we = $urandom_range(0, 1); _req_size = $urandom_range(0, 2);
      _req_vptr = $urandom_range(0, 255); _req_data = $urandom;
    end else begin
      _req_valid = 1'b0;
    end
    do begin
      @(negedge _clk);
      lat++;
    end while (!resp_valid_ && lat < 10);
    if (!resp_valid_) begin
      check("resp_timeout", resp_valid_, 1'b1);
      _req_valid = 1'b0;
      return;
    end
    if (stall > 0) begin
      repeat (stall) @(posedge _clk);
      #1 _resp_ready = 1'b1;
      @(negedge _clk);
    end
    rd  = resp_data_;
    mis = resp_misaligned_;
    @(posedge _clk); #1;
    _resp_ready = 1'b0;
    _req_valid  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        mis;
  int          lat, acc_wait, p0;
  logic [31:0] vptr;
  logic [1:0]  sz;
  int          r;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899_AABB;  ref_mem[4] = 32'h8899_AABB;

    _reset = 1'b0; _req_valid = 1'b1; _req_we = 1'b0; _req_size = 2'd2;
    _req_unsigned = 1'b0; _req_vptr = 32'h10; _req_data = '0; _resp_ready = 1'b0;
    repeat (3) @(posedge _clk);
    #1;
    check("rst_mem_we", mem_we_, 1'b0);
    check("rst_mem_vptr", mem_vptr_, 32'h0);
    check("rst_mem_data", mem_data_, 32'h0);
    check("rst_resp_valid", resp_valid_, 1'b0);
    check("rst_resp_data", resp_data_, 32'h0);
    check("rst_resp_mis", resp_misaligned_, 1'b0);
    check("rst_req_ready", req_ready_, 1'b0);
    _req_valid = 1'b0;
    @(posedge _clk); #1;
    _reset  = 1'b1;
    run_chk = 1'b1;
    @(negedge _clk);
    check("post_rst_ready", req_ready_, 1'b1);

    // Signed byte load from lane 1.
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, 1'b0, rd, mis, lat, acc_wait);
    check("t1_data", rd, 32'hFFFF_FFAA);
    check("t1_mis", mis, 1'b0);
    check("t1_lat", lat, 2);
    check("t1_rd_ptr", last_rd_ptr, 32'h10);

    // Upper half, unsigned then signed.
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 1'b0, rd, mis, lat, acc_wait);
    check("t2_half_u", rd, 32'h0000_8899);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1, 1'b0, rd, mis, lat, acc_wait);
    check("t2_half_s", rd, 32'hFFFF_8899);

    // Byte store into the top lane: one write pulse, merged word.
    p0 = we_pulses;
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFF_FF5A, 0, 1'b0, rd, mis, lat, acc_wait);
    check("t3_lat", lat, 3);
    check("t3_data", rd, 32'h0);
    check("t3_pulses", we_pulses - p0, 1);
    check("t3_we_ptr", last_we_ptr, 32'h10);
    check("t3_we_data", last_we_data, 32'h5A99_AABB);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, mis, lat, acc_wait);
    check("t3_readback", rd, 32'h5A99_AABB);

    // Faults: misaligned word store and illegal size.
    p0 = we_pulses;
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h1234_5678, 0, 1'b0, rd, mis, lat, acc_wait);
    check("t4_mis", mis, 1'b1);
    check("t4_lat", lat, 1);
    check("t4_data", rd, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h1234_5678, 0, 1'b0, rd, mis, lat, acc_wait);
    check("t4_sz3_mis", mis, 1'b1);
    check("t4_sz3_lat", lat, 1);
    check("t4_pulses", we_pulses - p0, 0);
    check("t4_mem", mem[4], 32'h5A99_AABB);

    // Backpressure with a competing request held on the input.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 1'b1, rd, mis, lat, acc_wait);
    check("t5_data", rd, 32'h5A99_AABB);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, 1'b0, rd, mis, lat, acc_wait);
    check("t5_next_wait", acc_wait, 0);
    check("t5_next_data", rd, 32'h0000_00BB);

    // Top of the address space.
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 1'b0, rd, mis, lat, acc_wait);
    check("wrap_store_lat", lat, 2);
    do_req(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, 0, 1'b0, rd, mis, lat, acc_wait);
    check("wrap_half", rd, 32'h0000_CAFE);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      vptr = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) vptr = 32'hFFFF_FF00 | vptr;
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'd1) vptr[0] = 1'b0;
        if (sz == 2'd2) vptr[1:0] = 2'b00;
      end
      do_req($urandom_range(0, 1), sz, $urandom_range(0, 1), vptr, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 1), rd, mis, lat, acc_wait);
    end

    // Reset in the middle of a byte store's write cycle.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899_AABB, 0, 1'b0, rd, mis, lat, acc_wait);
    @(posedge _clk); #1;
    _req_valid = 1'b1; _req_we = 1'b1; _req_size = 2'd0; _req_vptr = 32'h11; _req_data = 32'h77;
    @(negedge _clk);
    check("t6_accept", req_ready_, 1'b1);
    @(posedge _clk); #1;
    _req_valid = 1'b0;
    @(posedge _clk); #1;
    check("t6_we_up", mem_we_, 1'b1);
    _reset = 1'b0;
    #1;
    check("t6_we_drop", mem_we_, 1'b0);
    check("t6_ptr_drop", mem_vptr_, 32'h0);
    check("t6_ready_in_rst", req_ready_, 1'b0);
    repeat (2) @(posedge _clk);
    #1;
    check("t6_mem_intact", mem[4], 32'h8899_AABB);
    _reset = 1'b1;
    @(negedge _clk);
    check("t6_ready_after", req_ready_, 1'b1);
    repeat (4) begin
      @(negedge _clk);
      check("t6_no_resp", resp_valid_, 1'b0);
    end

    for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
